debug_trace_capture: RTL
========================

# debug_trace_capture

Change-capture trace buffer sitting directly downstream of the 32-bit DEBUG PIO output port. Watches the PIO `out_port` word every cycle and, when enabled, pushes each new value plus a free-running cycle timestamp into an internal FIFO. Firmware or the HPS drains the FIFO over an Avalon-MM slave to reconstruct a time-ordered trace of debug codes written by the RISC-V core.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of 2, 4..256.
- `TS_WIDTH`, 32: timestamp counter width, 1..32.

Ports:
- `clk`  in  1  clock; same domain as the DEBUG PIO.
- `reset_n`  in  1  asynchronous, active-low reset.
- `debug_in`  in  32  observed word (DEBUG PIO `out_port`).
- `address`  in  3  Avalon-MM word address.
- `chipselect`  in  1  slave select.
- `read_n`  in  1  active-low read strobe.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data; 0 wait states, read latency 0 (combinational from registers).
- `irq`  out  1  level interrupt: `irq_en && !empty`.

## Operation
- Register map (word addresses); unmapped addresses read 0, writes ignored:
  - 0 STATUS (RO): [0] empty, [1] full, [2] overflow (sticky), [16:8] count (0..DEPTH).
  - 1 CONTROL (RW): [0] enable, [1] irq_en; [2] clear (write-1, self-clearing, reads 0): empties FIFO and clears overflow.
  - 2 HEAD_TS (RO): timestamp of head entry, zero-extended; 0 when empty; no side effect.
  - 3 HEAD_VAL (RO): value of head entry; 0 when empty; read with FIFO non-empty pops the head.
  - 4 NOW (RO): live timestamp counter.
  - 5 LAST (RO): `last_val`, the previous-cycle sample of `debug_in`.
- `last_val` <= `debug_in` every cycle, regardless of enable.
- Capture condition in cycle N: `enable && debug_in != last_val`; pushes {ts_counter, debug_in} sampled in cycle N.
- `ts_counter` increments every cycle, wraps modulo 2^TS_WIDTH, never stops.
- Push while full and no pop in same cycle: entry dropped, overflow set; overflow cleared only by CONTROL.clear or reset.
- Push and pop in same cycle: both take effect; count unchanged; valid when full (no overflow) and when count==1.
- Pop while empty: no effect, readdata 0.
- CONTROL.clear coinciding with push: clear wins, capture discarded; with enable written in same write, enable takes the written value.
- Reset values: all FIFO pointers/count 0, empty=1, full=0, overflow=0, enable=0, irq_en=0, `last_val`=0, `ts_counter`=0, `irq`=0, `readdata` reflects registers (STATUS reads 0x0000_0001).

## Timing
- Change on `debug_in` in cycle N -> STATUS.empty falls and count increments at edge ending cycle N; visible to reads in cycle N+1.
- HEAD_VAL read in cycle M returns the head combinationally; pointer advances at edge ending M; next head visible in M+1.
- CONTROL writes take effect at edge ending the write cycle; capture in that same cycle uses the old enable.
- `irq` is registered-path derived (from enable regs and count), no combinational path from Avalon inputs.
- Reset asserted mid-operation: all state returns to reset values asynchronously; contents lost.

## Structure
- Shared package `debug_trace_pkg`: register address constants (ADDR_STATUS..ADDR_LAST), STATUS/CONTROL bit positions.
- Sub-module `debug_trace_fifo`: synchronous FIFO, width 32+TS_WIDTH, DEPTH entries, count/empty/full outputs, show-ahead head, push/pop/clear inputs, simultaneous push+pop at full supported.
- Top: change detector, timestamp counter, CSRs, read mux, overflow/irq logic.

## Test plan
- Reset, read STATUS -> 0x0000_0001; NOW advances by read spacing; LAST = 0.
- enable=1, drive `debug_in` 0x0->0xA5 at cycle where NOW=100, then hold -> exactly one entry; HEAD_TS=100, HEAD_VAL=0xA5, then empty.
- enable=0, toggle `debug_in` 5 times -> FIFO stays empty, LAST tracks input.
- DEPTH=16, 17 distinct changes without reads -> count=16, full=1, overflow=1; drain yields first 16 values in order; write CONTROL=0x5 -> STATUS=0x0000_0001.
- Full FIFO, HEAD_VAL read in same cycle as new change -> count stays 16, overflow stays 0, new value last out.
- irq_en=1: one change -> `irq`=1 next cycle; pop it -> `irq`=0; assert reset_n low mid-stream -> `irq`=0, empty=1 immediately.

Source files
------------

// File: rtl/debug_trace_pkg.sv
// debug_trace_pkg: register map and bit positions shared by the trace capture block
package debug_trace_pkg;
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_HEAD_TS  = 3'd2;
  localparam logic [2:0] ADDR_HEAD_VAL = 3'd3;
  localparam logic [2:0] ADDR_NOW      = 3'd4;
  localparam logic [2:0] ADDR_LAST     = 3'd5;
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 8;
  localparam int CTL_ENABLE   = 0;
  localparam int CTL_IRQ_EN   = 1;
  localparam int CTL_CLEAR    = 2;
endpackage

// File: rtl/debug_trace_fifo.sv
// debug_trace_fifo: show-ahead synchronous FIFO with clear and push+pop at full
module debug_trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign head    = mem[rd_ptr];
  // storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk)
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  // pointer and occupancy tracking; clear dominates any same-cycle push/pop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/debug_trace_capture.sv
// debug_trace_capture: timestamps changes on the debug PIO word and queues them for Avalon-MM readout
module debug_trace_capture
  import debug_trace_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] debug_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  localparam int W  = 32 + TS_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [TS_WIDTH-1:0] ts_counter;
  logic [31:0] last_val, status, head_ts, head_val;
  logic [W-1:0] head;
  logic [CW-1:0] count;
  logic enable, irq_en, overflow, empty, full;
  logic rd, ctl_wr, clear, capture, pop;
  logic unused_wdata;
  assign rd           = chipselect & ~read_n;
  assign ctl_wr       = chipselect & ~write_n & (address == ADDR_CONTROL);
  assign clear        = ctl_wr & writedata[CTL_CLEAR];
  assign capture      = enable & (debug_in != last_val);
  assign pop          = rd & (address == ADDR_HEAD_VAL);
  assign unused_wdata = ^writedata[31:3];
  debug_trace_fifo #(.WIDTH(W), .DEPTH(DEPTH)) fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (capture),
    .pop     (pop),
    .clear   (clear),
    .wdata   ({ts_counter, debug_in}),
    .head    (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );
  // sampler, free-running timestamp, control bits and sticky overflow
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_val   <= '0;
      ts_counter <= '0;
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      last_val   <= debug_in;
      ts_counter <= ts_counter + TS_WIDTH'(1);
      if (ctl_wr) begin
        enable <= writedata[CTL_ENABLE];
        irq_en <= writedata[CTL_IRQ_EN];
      end
      overflow <= clear ? 1'b0 : (overflow | (capture & full & ~pop));
    end
  assign irq      = irq_en & ~empty;
  assign status   = {15'd0, 9'(count), 5'd0, overflow, full, empty};
  assign head_ts  = empty ? '0 : 32'(head[W-1:32]);
  assign head_val = empty ? '0 : head[31:0];
  // zero-wait-state read mux straight from registers
  always_comb
    readdata = address == ADDR_STATUS   ? status :
               address == ADDR_CONTROL  ? {30'd0, irq_en, enable} :
               address == ADDR_HEAD_TS  ? head_ts :
               address == ADDR_HEAD_VAL ? head_val :
               address == ADDR_NOW      ? 32'(ts_counter) :
               address == ADDR_LAST     ? last_val : '0;
endmodule
